// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM input-side blocks.
//   pwm_state_e   : capture FSM state encoding (2 bits)
//   PWM_WIDTH_DEF : default counter/result width
package pwm_pkg;

  localparam int PWM_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_HIGH  = 2'd2,
    ST_LOW   = 2'd3
  } pwm_state_e;

endpackage

// File: rtl/pwm_sync_edge.sv
// Two-flop synchronizer followed by one extra register, used to bring an
// asynchronous level into the clock domain and detect its edges.
// Ports:
//   clk_i   : clock, all flops rise on posedge
//   rst_i   : synchronous active-high reset, clears all three flops
//   d_i     : asynchronous input level
//   level_o : synchronized level (second sync flop)
//   rise_o  : one-cycle pulse on a synchronized 0->1 transition
//   fall_o  : one-cycle pulse on a synchronized 1->0 transition
module pwm_sync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign level_o = s2_q;
  assign rise_o  = s2_q & ~s3_q;
  assign fall_o  = ~s2_q & s3_q;

endmodule

// File: rtl/pwm_capture_unit.sv
// Measures high time and period of an incoming PWM waveform in clock cycles
// and reports them as value = high cycles, range = period - 1.
// Ports:
//   pwm_clk        : clock
//   pwm_reset      : synchronous active-high reset
//   pwm_en         : capture enable; low returns the FSM to IDLE
//   pwm_in         : PWM input, may be asynchronous
//   cap_value      : last measured high time
//   cap_range      : last measured period - 1
//   cap_valid      : one-cycle pulse when cap_value/cap_range update
//   cap_stuck_high : sticky, input stayed high for 2**PWM_WIDTH cycles
//   cap_stuck_low  : sticky, input stayed low for 2**PWM_WIDTH cycles
module pwm_capture_unit
  import pwm_pkg::*;
#(
  parameter int PWM_WIDTH = PWM_WIDTH_DEF
) (
  input  logic                 pwm_clk,
  input  logic                 pwm_reset,
  input  logic                 pwm_en,
  input  logic                 pwm_in,
  output logic [PWM_WIDTH-1:0] cap_value,
  output logic [PWM_WIDTH-1:0] cap_range,
  output logic                 cap_valid,
  output logic                 cap_stuck_high,
  output logic                 cap_stuck_low
);

  localparam logic [PWM_WIDTH:0]   CNT_MAX = {1'b1, {PWM_WIDTH{1'b0}}};
  localparam logic [PWM_WIDTH:0]   CNT_ONE = {{PWM_WIDTH{1'b0}}, 1'b1};
  localparam logic [PWM_WIDTH-1:0] ONE_W   = {{(PWM_WIDTH-1){1'b0}}, 1'b1};

  // Counter saturates at 2**PWM_WIDTH so a dead input cannot wrap it.
  function automatic logic [PWM_WIDTH:0] sat_inc(input logic [PWM_WIDTH:0] c);
    return (c == CNT_MAX) ? CNT_MAX : c + CNT_ONE;
  endfunction

  logic lvl, rise, fall;

  pwm_sync_edge u_sync (
    .clk_i   (pwm_clk),
    .rst_i   (pwm_reset),
    .d_i     (pwm_in),
    .level_o (lvl),
    .rise_o  (rise),
    .fall_o  (fall)
  );

  pwm_state_e           state_q;
  logic [PWM_WIDTH:0]   cnt_q, cnt_d;
  logic [PWM_WIDTH-1:0] hi_len_q;
  logic [PWM_WIDTH-1:0] value_q, range_q, range_d;
  logic                 valid_q, stuck_hi_q, stuck_lo_q;
  logic                 cnt_at_max;

  // cnt restarts at 1 on every rise, so at the next rise it equals the period.
  // A full period of 2**W leaves the low bits at 0; 0 - 1 wraps to the
  // correct range value of 2**W - 1.
  always_comb begin
    cnt_d      = rise ? CNT_ONE : sat_inc(cnt_q);
    range_d    = cnt_q[PWM_WIDTH-1:0] - ONE_W;
    cnt_at_max = (cnt_q == CNT_MAX);
  end

  always_ff @(posedge pwm_clk) begin
    if (pwm_reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      value_q    <= '0;
      range_q    <= '0;
      valid_q    <= 1'b0;
      stuck_hi_q <= 1'b0;
      stuck_lo_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (!pwm_en) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_d;
        case (state_q)
          // Wait for a low level so the first rise seen is a genuine one.
          ST_IDLE: begin
            if (!lvl) begin
              state_q <= ST_ARMED;
            end else if (cnt_at_max) begin
              stuck_hi_q <= 1'b1;
              stuck_lo_q <= 1'b0;
            end
          end
          // First rise only starts timing; its partial pulse is discarded.
          ST_ARMED: begin
            if (rise) begin
              state_q <= ST_HIGH;
            end else if (cnt_at_max) begin
              stuck_lo_q <= 1'b1;
              stuck_hi_q <= 1'b0;
            end
          end
          ST_HIGH: begin
            if (fall) begin
              state_q  <= ST_LOW;
              hi_len_q <= cnt_q[PWM_WIDTH-1:0];
            end else if (cnt_at_max) begin
              stuck_hi_q <= 1'b1;
              stuck_lo_q <= 1'b0;
              state_q    <= ST_IDLE;
            end
          end
          // Rise closes the period; it wins over a coincident cnt == max.
          ST_LOW: begin
            if (rise) begin
              value_q    <= hi_len_q;
              range_q    <= range_d;
              valid_q    <= 1'b1;
              stuck_hi_q <= 1'b0;
              stuck_lo_q <= 1'b0;
              state_q    <= ST_HIGH;
            end else if (cnt_at_max) begin
              stuck_lo_q <= 1'b1;
              stuck_hi_q <= 1'b0;
              state_q    <= ST_ARMED;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign cap_value      = value_q;
  assign cap_range      = range_q;
  assign cap_valid      = valid_q;
  assign cap_stuck_high = stuck_hi_q;
  assign cap_stuck_low  = stuck_lo_q;

endmodule

// File: tb/tb_pwm_capture_unit.sv
// Self-checking bench for pwm_capture_unit. Waveforms are described as lists
// of (high, low) pulse lengths; the expected measurements and their timing
// are derived from those lists: every rise after the first one in a run
// reports the previous pulse (value = high, range = high + low - 1), two
// edges after the rise is first sampled.
module tb_pwm_capture_unit;

  localparam int W = 8;
  localparam int MAXP = 1 << W;

  logic         clk = 1'b0;
  logic         pwm_reset, pwm_en, pwm_in;
  logic [W-1:0] cap_value, cap_range;
  logic         cap_valid, cap_stuck_high, cap_stuck_low;

  int checks = 0;
  int failures = 0;
  int edge_n = 0;

  int obs_edge[$], obs_val[$], obs_rng[$];
  int sl_set_edge = -1, sl_clr_edge = -1, sh_set_edge = -1;
  logic sl_prev = 1'b0, sh_prev = 1'b0;
  int both_seen = 0;

  int q_h[$], q_l[$];
  int last_rise_e[$];

  pwm_capture_unit #(.PWM_WIDTH(W)) dut (
    .pwm_clk        (clk),
    .pwm_reset      (pwm_reset),
    .pwm_en         (pwm_en),
    .pwm_in         (pwm_in),
    .cap_value      (cap_value),
    .cap_range      (cap_range),
    .cap_valid      (cap_valid),
    .cap_stuck_high (cap_stuck_high),
    .cap_stuck_low  (cap_stuck_low)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  // Observation only: records events with the number of the edge that produced them.
  always @(negedge clk) begin
    if (cap_valid === 1'b1) begin
      obs_edge.push_back(edge_n);
      obs_val.push_back(int'(cap_value));
      obs_rng.push_back(int'(cap_range));
    end
    if (cap_stuck_low && !sl_prev) sl_set_edge = edge_n;
    if (!cap_stuck_low && sl_prev) sl_clr_edge = edge_n;
    if (cap_stuck_high && !sh_prev) sh_set_edge = edge_n;
    if (cap_stuck_low && cap_stuck_high) both_seen++;
    sl_prev = cap_stuck_low;
    sh_prev = cap_stuck_high;
  end

  task automatic step(input logic v);
    pwm_in = v;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic v);
    pwm_reset = 1'b1;
    repeat (3) step(v);
    pwm_reset = 1'b0;
  endtask

  task automatic clear_obs();
    obs_edge.delete();
    obs_val.delete();
    obs_rng.delete();
  endtask

  // Plays q_h/q_l and checks every reported measurement against the pulse list.
  task automatic play_pulses(input int lead, input string tag);
    int n_exp, e_e, e_v, e_r;
    clear_obs();
    last_rise_e.delete();
    repeat (lead) step(1'b0);
    for (int i = 0; i < q_h.size(); i++) begin
      for (int j = 0; j < q_h[i]; j++) begin
        step(1'b1);
        if (j == 0) last_rise_e.push_back(edge_n);
      end
      for (int j = 0; j < q_l[i]; j++) step(1'b0);
    end
    repeat (4) step(1'b0);
    n_exp = q_h.size() - 1;
    checks++;
    if (obs_edge.size() != n_exp) begin
      failures++;
      $display("FAIL %s_count: got %0d valid pulses, expected %0d", tag, obs_edge.size(), n_exp);
    end
    for (int i = 1; i < q_h.size(); i++) begin
      if (i - 1 < obs_edge.size()) begin
        e_e = last_rise_e[i] + 2;
        e_v = q_h[i-1];
        e_r = q_h[i-1] + q_l[i-1] - 1;
        checks++;
        if (obs_edge[i-1] !== e_e) begin
          failures++;
          $display("FAIL %s_time[%0d]: got edge %0d, expected %0d", tag, i, obs_edge[i-1], e_e);
        end
        checks++;
        if (obs_val[i-1] !== e_v) begin
          failures++;
          $display("FAIL %s_value[%0d]: got %0d, expected %0d", tag, i, obs_val[i-1], e_v);
        end
        checks++;
        if (obs_rng[i-1] !== e_r) begin
          failures++;
          $display("FAIL %s_range[%0d]: got %0d, expected %0d", tag, i, obs_rng[i-1], e_r);
        end
      end
    end
  endtask

  task automatic fill(input int n, input int h, input int l);
    q_h.delete();
    q_l.delete();
    for (int i = 0; i < n; i++) begin
      q_h.push_back(h);
      q_l.push_back(l);
    end
  endtask

  task automatic check_outputs(input string tag, input int v, input int r,
                               input logic sh, input logic sl);
    checks++;
    if (int'(cap_value) !== v) begin
      failures++;
      $display("FAIL %s_value: got %0d, expected %0d", tag, cap_value, v);
    end
    checks++;
    if (int'(cap_range) !== r) begin
      failures++;
      $display("FAIL %s_range: got %0d, expected %0d", tag, cap_range, r);
    end
    checks++;
    if (cap_stuck_high !== sh) begin
      failures++;
      $display("FAIL %s_stuck_high: got %0b, expected %0b", tag, cap_stuck_high, sh);
    end
    checks++;
    if (cap_stuck_low !== sl) begin
      failures++;
      $display("FAIL %s_stuck_low: got %0b, expected %0b", tag, cap_stuck_low, sl);
    end
  endtask

  task automatic test_reset();
    pwm_en = 1'b1;
    do_reset(1'b0);
    check_outputs("reset", 0, 0, 1'b0, 1'b0);
    checks++;
    if (cap_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid: got %0b, expected 0", cap_valid);
    end
  endtask

  task automatic test_period_256();
    do_reset(1'b0);
    fill(5, 64, 192);
    q_l[4] = 20;
    play_pulses(10, "p256");
    check_outputs("p256_end", 64, 255, 1'b0, 1'b0);
  endtask

  task automatic test_toggle();
    do_reset(1'b0);
    fill(20, 1, 1);
    play_pulses(3, "toggle");
    check_outputs("toggle_end", 1, 1, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    do_reset(1'b0);
    q_h.delete();
    q_l.delete();
    for (int i = 0; i < 14; i++) begin
      q_h.push_back(int'($urandom_range(1, 60)));
      q_l.push_back(int'($urandom_range(1, 60)));
    end
    play_pulses(3, "random");
    check_outputs("random_end", q_h[12], q_h[12] + q_l[12] - 1, 1'b0, 1'b0);
  endtask

  task automatic test_stuck_low();
    int act_e, n_before;
    do_reset(1'b0);
    fill(4, 30, 70);
    play_pulses(5, "slow_pre");
    act_e = last_rise_e[3] + 2;
    n_before = obs_edge.size();
    sl_set_edge = -1;
    repeat (400) step(1'b0);
    checks++;
    if (obs_edge.size() != n_before) begin
      failures++;
      $display("FAIL slow_novalid: got %0d pulses, expected %0d", obs_edge.size(), n_before);
    end
    checks++;
    if (sl_set_edge !== act_e + MAXP) begin
      failures++;
      $display("FAIL slow_set_time: got edge %0d, expected %0d", sl_set_edge, act_e + MAXP);
    end
    check_outputs("slow_hold", 30, 99, 1'b0, 1'b1);
    sl_clr_edge = -1;
    fill(3, 30, 70);
    play_pulses(0, "slow_resume");
    checks++;
    if (sl_clr_edge !== last_rise_e[1] + 2) begin
      failures++;
      $display("FAIL slow_clr_time: got edge %0d, expected %0d", sl_clr_edge, last_rise_e[1] + 2);
    end
    check_outputs("slow_resume_end", 30, 99, 1'b0, 1'b0);
  endtask

  task automatic test_stuck_high();
    int rst_e;
    clear_obs();
    do_reset(1'b1);
    rst_e = edge_n;
    sh_set_edge = -1;
    repeat (300) step(1'b1);
    checks++;
    if (obs_edge.size() != 0) begin
      failures++;
      $display("FAIL shigh_novalid: got %0d pulses, expected 0", obs_edge.size());
    end
    // Input first sampled at rst_e+1, rise acted on two edges later.
    checks++;
    if (sh_set_edge !== rst_e + 3 + MAXP) begin
      failures++;
      $display("FAIL shigh_set_time: got edge %0d, expected %0d", sh_set_edge, rst_e + 3 + MAXP);
    end
    check_outputs("shigh_end", 0, 0, 1'b1, 1'b0);
  endtask

  task automatic test_enable_drop();
    do_reset(1'b0);
    fill(3, 40, 60);
    play_pulses(5, "en_pre");
    clear_obs();
    repeat (10) step(1'b1);
    pwm_en = 1'b0;
    repeat (10) step(1'b1);
    pwm_en = 1'b1;
    repeat (10) step(1'b1);
    repeat (50) step(1'b0);
    // The rise at the start of this section closed a 40-high, 64-low period.
    checks++;
    if (obs_edge.size() != 1) begin
      failures++;
      $display("FAIL en_mid_count: got %0d pulses, expected 1", obs_edge.size());
    end
    check_outputs("en_hold", 40, 103, 1'b0, 1'b0);
    fill(3, 40, 60);
    play_pulses(0, "en_post");
  endtask

  task automatic test_reset_on_rise();
    int n_before;
    do_reset(1'b0);
    fill(2, 20, 30);
    play_pulses(5, "rr_pre");
    repeat (20) step(1'b0);
    n_before = obs_edge.size();
    step(1'b1);
    step(1'b1);
    pwm_reset = 1'b1;
    step(1'b1);
    pwm_reset = 1'b0;
    check_outputs("rr_after", 0, 0, 1'b0, 1'b0);
    repeat (5) step(1'b0);
    checks++;
    if (obs_edge.size() != n_before) begin
      failures++;
      $display("FAIL rr_novalid: got %0d pulses, expected %0d", obs_edge.size(), n_before);
    end
  endtask

  initial begin
    pwm_reset = 1'b1;
    pwm_en    = 1'b1;
    pwm_in    = 1'b0;
    test_reset();
    test_period_256();
    test_toggle();
    test_random();
    test_stuck_low();
    test_stuck_high();
    test_enable_drop();
    test_reset_on_rise();
    checks++;
    if (both_seen != 0) begin
      failures++;
      $display("FAIL stuck_both: flags high together on %0d cycles, expected 0", both_seen);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached, expected bench to finish");
    $fatal(1, "watchdog");
  end

endmodule
